// File: rtl/code_link_pkg.sv
// rtl/code_link_pkg.sv - shared definitions for the one-bit unlock-code link
package code_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_RESP,
        LOCKED
    } code_tx_state_t;

    localparam int CODE_LINK_W = 4;

    // Also compiled into the checker; both ends must agree on it.
    localparam logic [CODE_LINK_W-1:0] DEFAULT_UNLOCK_CODE = 4'b1011;

endpackage

// File: rtl/code_tx_serializer.sv
// rtl/code_tx_serializer.sv - MSB-first shift register with per-bit hold counter
module code_tx_serializer #(
    parameter int W          = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] data,
    input  logic         en,
    output logic         bit_out,
    output logic         last
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  sreg;
    logic [CW-1:0] cyc;
    logic [IW-1:0] idx;
    logic          bit_end;

    assign bit_end = (cyc == CW'(BIT_CYCLES - 1));
    assign last    = en && bit_end && (idx == IW'(W - 1));
    // Zero-fill means the line idles low once the final bit has been shifted out.
    assign bit_out = sreg[W-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
            cyc  <= '0;
            idx  <= '0;
        end else if (load) begin
            sreg <= data;
            cyc  <= '0;
            idx  <= '0;
        end else if (en) begin
            if (bit_end) begin
                sreg <= sreg << 1;
                cyc  <= '0;
                idx  <= last ? '0 : idx + IW'(1);
            end else begin
                cyc <= cyc + CW'(1);
            end
        end
    end

endmodule

// File: rtl/code_tx.sv
// rtl/code_tx.sv - serial unlock-code transmitter with attempt lockout; CODE_TX_TIMEOUT_EN adds a verdict timeout
module code_tx
    import code_link_pkg::*;
#(
    parameter int CODE_W       = CODE_LINK_W,
    parameter int BIT_CYCLES   = 1,
    parameter int MAX_ATTEMPTS = 3,
    parameter int RESP_TIMEOUT = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              load_valid,
    output logic                              load_ready,
    input  logic [CODE_W-1:0]                 load_code,
    output logic                              code_out,
    output logic                              tx_active,
    input  logic                              result_done,
    input  logic                              result_fail,
    output logic                              tx_ok,
    output logic                              tx_fail,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts,
    output logic                              locked
);

    localparam int AW = $clog2(MAX_ATTEMPTS + 1);

    code_tx_state_t state, next_state;
    logic           load_fire;
    logic           ser_last;
    logic           timeout_hit;
    logic           ok_now;
    logic           fail_now;
    logic [AW-1:0]  attempts_inc;

    assign load_fire    = load_valid && load_ready;
    assign attempts_inc = (attempts < AW'(MAX_ATTEMPTS)) ? attempts + AW'(1) : attempts;

    code_tx_serializer #(
        .W          (CODE_W),
        .BIT_CYCLES (BIT_CYCLES)
    ) u_ser (
        .clk     (clk),
        .reset   (reset),
        .load    (load_fire),
        .data    (load_code),
        .en      (state == SHIFT),
        .bit_out (code_out),
        .last    (ser_last)
    );

`ifdef CODE_TX_TIMEOUT_EN
    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    assign timeout_hit = (state == WAIT_RESP) && (wait_cnt == TW'(RESP_TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != WAIT_RESP) begin
            wait_cnt <= '0;
        end else if (!timeout_hit) begin
            wait_cnt <= wait_cnt + TW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        next_state = state;
        ok_now     = 1'b0;
        fail_now   = 1'b0;
        case (state)
            IDLE:      if (load_fire) next_state = SHIFT;
            SHIFT:     if (ser_last) next_state = WAIT_RESP;
            WAIT_RESP: begin
                // A fail wins over a simultaneous done; a real verdict wins over the timeout.
                if (result_fail)      fail_now = 1'b1;
                else if (result_done) ok_now   = 1'b1;
                else if (timeout_hit) fail_now = 1'b1;
                if (ok_now) next_state = IDLE;
                if (fail_now) next_state = (attempts_inc == AW'(MAX_ATTEMPTS)) ? LOCKED : IDLE;
            end
            LOCKED:    next_state = LOCKED;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            load_ready <= 1'b0;
            tx_active  <= 1'b0;
            tx_ok      <= 1'b0;
            tx_fail    <= 1'b0;
            attempts   <= '0;
            locked     <= 1'b0;
        end else begin
            state      <= next_state;
            load_ready <= (next_state == IDLE);
            tx_active  <= (next_state == SHIFT);
            tx_ok      <= ok_now;
            tx_fail    <= fail_now;
            locked     <= (next_state == LOCKED);
            if (ok_now)        attempts <= '0;
            else if (fail_now) attempts <= attempts_inc;
        end
    end

endmodule

// File: tb/tb_code_tx.sv
// tb/tb_code_tx.sv - scoreboard bench for code_tx (default build and BIT_CYCLES=3 instance)
module tb_code_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [3:0] load_code = 4'h0;
    logic       code_out;
    logic       tx_active;
    logic       result_done = 1'b0;
    logic       result_fail = 1'b0;
    logic       tx_ok;
    logic       tx_fail;
    logic [1:0] attempts;
    logic       locked;

    logic       load_valid_3 = 1'b0;
    logic       load_ready_3;
    logic [3:0] load_code_3 = 4'h0;
    logic       code_out_3;
    logic       tx_active_3;
    logic       result_done_3 = 1'b0;
    logic       tx_ok_3;
    logic       tx_fail_3;
    logic [1:0] attempts_3;
    logic       locked_3;

    int n_checks = 0;
    int n_pass   = 0;
    int act_cnt  = 0;
    int act3_cnt = 0;
    logic exp_q[$];
    logic exp3_q[$];

    always #5 clk = ~clk;

    code_tx dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_code   (load_code),
        .code_out    (code_out),
        .tx_active   (tx_active),
        .result_done (result_done),
        .result_fail (result_fail),
        .tx_ok       (tx_ok),
        .tx_fail     (tx_fail),
        .attempts    (attempts),
        .locked      (locked)
    );

    code_tx #(.BIT_CYCLES(3)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid_3),
        .load_ready  (load_ready_3),
        .load_code   (load_code_3),
        .code_out    (code_out_3),
        .tx_active   (tx_active_3),
        .result_done (result_done_3),
        .result_fail (1'b0),
        .tx_ok       (tx_ok_3),
        .tx_fail     (tx_fail_3),
        .attempts    (attempts_3),
        .locked      (locked_3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (tx_active) begin
            act_cnt++;
            if (exp_q.size() == 0) check("bit_extra", 1, 0);
            else check("code_bit", code_out, exp_q.pop_front());
        end
        if (tx_active_3) begin
            act3_cnt++;
            if (exp3_q.size() == 0) check("bit3_extra", 1, 0);
            else check("code_bit3", code_out_3, exp3_q.pop_front());
        end
    end

    task automatic send(input logic [3:0] c);
        int n = 0;
        while (!load_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 0, 1);
        act_cnt = 0;
        load_valid = 1'b1;
        load_code  = c;
        for (int k = 3; k >= 0; k--) exp_q.push_back(c[k]);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_code  = ~c;
    endtask

    task automatic wait_shift_done();
        int n = 0;
        @(negedge clk);
        while (tx_active && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("shift_timeout", 0, 1);
    endtask

    task automatic verdict(input logic d, input logic f);
        result_done = d;
        result_fail = f;
        @(posedge clk);
        #1;
        result_done = 1'b0;
        result_fail = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_load_ready"}, load_ready, 0);
        check({tag, "_code_out"}, code_out, 0);
        check({tag, "_tx_active"}, tx_active, 0);
        check({tag, "_tx_ok"}, tx_ok, 0);
        check({tag, "_tx_fail"}, tx_fail, 0);
        check({tag, "_attempts"}, attempts, 0);
        check({tag, "_locked"}, locked, 0);
    endtask

    initial begin
        int n;
        logic saw_fail;

        #2;
        check_reset_values("rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", load_ready, 1);

        // Default code, accepted
        send(4'b1011);
        wait_shift_done();
        check("active_len", act_cnt, 4);
        check("code_out_wait", code_out, 0);
        check("ready_in_wait", load_ready, 0);
        verdict(1'b1, 1'b0);
        check("ok_pulse", tx_ok, 1);
        check("ok_no_fail", tx_fail, 0);
        check("ok_attempts", attempts, 0);
        check("ok_ready", load_ready, 1);
        @(posedge clk);
        #1;
        check("ok_one_cycle", tx_ok, 0);

        // Simultaneous done and fail counts as a fail, then done clears the count
        send(4'b1011);
        wait_shift_done();
        verdict(1'b1, 1'b1);
        check("both_fail", tx_fail, 1);
        check("both_no_ok", tx_ok, 0);
        check("both_attempts", attempts, 1);
        send(4'b0100);
        wait_shift_done();
        verdict(1'b1, 1'b0);
        check("clear_attempts", attempts, 0);

        // Three consecutive failures lock the block
        for (int i = 1; i <= 3; i++) begin
            send(4'b1011);
            wait_shift_done();
            verdict(1'b0, 1'b1);
            check("fail_pulse", tx_fail, 1);
            check("fail_attempts", attempts, i);
            check("fail_locked", locked, (i == 3));
            check("fail_ready", load_ready, (i != 3));
        end
        act_cnt = 0;
        load_valid = 1'b1;
        load_code  = 4'b1111;
        result_done = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        load_valid = 1'b0;
        result_done = 1'b0;
        check("lock_no_shift", act_cnt, 0);
        check("lock_no_ok", tx_ok, 0);
        check("lock_held", locked, 1);
        check("lock_attempts_sat", attempts, 3);
        check("lock_code_out", code_out, 0);

        // Reset exits lockout
        reset = 1'b1;
        #1;
        check("unlock_locked", locked, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Reset in the middle of the second bit
        send(4'b1011);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        check_reset_values("midrst");
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", load_ready, 1);

        // Missing verdict
        send(4'b0101);
        wait_shift_done();
        n = 0;
        saw_fail = 1'b0;
`ifdef CODE_TX_TIMEOUT_EN
        while (!tx_fail && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_latency", n, 16);
        check("timeout_fail", tx_fail, 1);
        check("timeout_attempts", attempts, 1);
`else
        repeat (30) begin
            @(posedge clk);
            #1;
            if (tx_fail) saw_fail = 1'b1;
        end
        check("no_timeout_fail", saw_fail, 0);
        check("no_timeout_waiting", load_ready, 0);
        @(negedge clk);
        verdict(1'b1, 1'b0);
        check("late_ok", tx_ok, 1);
`endif

        // BIT_CYCLES=3 instance
        check("ready3", load_ready_3, 1);
        act3_cnt = 0;
        load_valid_3 = 1'b1;
        load_code_3  = 4'b0110;
        for (int k = 3; k >= 0; k--) repeat (3) exp3_q.push_back(load_code_3[k]);
        @(posedge clk);
        #1;
        load_valid_3 = 1'b0;
        load_code_3  = 4'b1001;
        n = 0;
        @(negedge clk);
        while (tx_active_3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("active3_len", act3_cnt, 12);
        check("code_out3_wait", code_out_3, 0);
        result_done_3 = 1'b1;
        @(posedge clk);
        #1 result_done_3 = 1'b0;
        check("ok3_pulse", tx_ok_3, 1);

        check("exp_q_drained", exp_q.size(), 0);
        check("exp3_q_drained", exp3_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
